exe_mem_stage: RTL and testbench
================================

# exe_mem_stage

Parametrised EXE→MEM pipeline stage register for the MIPS pipeline with a valid/ready handshake, hazard-unit flush, gated control outputs and a saturating stall counter. It sits between the ALU/forwarding logic of the execute stage and the data-memory stage. An optional skid buffer can be compiled in to register the upstream `in_ready` path.

## Interface
- `WIDTH`, 32: width of `aluout` and `writedata` (data path).
- `RA_W`, 5: register-file address width.
- `SCNT_W`, 16: stall-counter width.

- `clk` input 1: rising-edge clock.
- `rst` input 1: asynchronous, active-low reset.
- `in_valid` input 1: execute stage presents a valid instruction.
- `in_ready` output 1: stage accepts a transfer this cycle.
- `regwrite_exe`, `memtoreg_exe`, `memwrite_exe` input 1 each: control bits.
- `aluout_exe` input WIDTH: ALU result.
- `writedata_exe` input WIDTH: store data.
- `regaddr_exe` input RA_W: destination register.
- `flush` input 1: kill everything held and arriving this cycle.
- `out_ready` input 1: MEM stage can take the head entry (0 = stall).
- `out_valid` output 1: head entry valid.
- `regwrite_mem`, `memtoreg_mem`, `memwrite_mem` output 1 each: control bits, gated by `out_valid`.
- `aluout_mem`, `writedata_mem` output WIDTH: head-entry data.
- `regaddr_mem` output RA_W: head-entry destination.
- `stall_cnt` output SCNT_W: saturating count of stalled cycles.

## Operation
- Input transfer: `in_valid && in_ready && !flush`. Output transfer: `out_valid && out_ready`.
- Main register: holds one entry (valid bit, 3 control bits, data). It loads when the register is empty, or when it is being drained in the same cycle.
- Control gating: `regwrite_mem`, `memtoreg_mem` and `memwrite_mem` equal the stored bit AND `out_valid`, so a bubble can never write the register file or memory.
- Data outputs (`aluout_mem`, `writedata_mem`, `regaddr_mem`) hold their last loaded value while a bubble is present. They are not cleared on flush.
- Flush: at the clock edge, every valid bit goes to 0 and any same-cycle input is dropped. Flush takes priority over both transfers. It does not affect `stall_cnt`.
- Stall counter: increments on every cycle with `out_valid && !out_ready`, saturates at 2^SCNT_W−1, and is cleared only by reset.
- Back-to-back: with `out_ready` = 1 held, one entry is accepted and one retired per cycle, with no bubbles.

## Timing
- Latency: an entry accepted at edge N is on the outputs after edge N (1 cycle).
- Reset (asynchronous, `rst` = 0): all valid bits, control bits, data registers and `stall_cnt` go to 0. Hence `out_valid` = 0, all `*_mem` = 0 and `stall_cnt` = 0.
- `in_ready` during reset and the first cycle after: 1.
- Reset asserted mid-stall: the held entry is lost immediately, without waiting for a clock edge.
- Without skid: `in_ready = !out_valid || out_ready`, a combinational path from `out_ready`.

## Configuration
- Macro: `EXE_MEM_SKID_EN`.
- Defined: adds a second (skid) entry and makes `in_ready` a register equal to "skid entry empty".
  - If `out_ready` falls while an input is accepted, the input goes to the skid entry.
  - When the head drains, the skid entry moves to the head on the next edge, and `in_ready` returns to 1 the cycle after the skid empties.
  - Ordering is strictly FIFO, with 2 entries at most.
  - Flush clears both entries.
  - Latency is 1 cycle when the skid is empty.
- Undefined: single entry and combinational `in_ready` as above. The skid logic is absent entirely.

## Test plan
- Reset: drive `rst` = 0 mid-cycle with a valid entry held → `out_valid`, `regwrite_mem`, `aluout_mem` and `stall_cnt` read 0 immediately, and `in_ready` = 1.
- Streaming: 8 back-to-back entries with `aluout_exe` = 0x10..0x17 and `out_ready` = 1 → `aluout_mem` shows 0x10..0x17 on consecutive cycles, each one cycle after its input.
- Stall: hold `out_ready` = 0 for 3 cycles with an entry 0xABCD held → outputs stay at 0xABCD and `stall_cnt` goes 0→3. Without skid, `in_ready` = 0 during the stall. With skid, exactly one more entry is accepted, and it is delivered after 0xABCD.
- Flush with store: hold `memwrite` = 1 and `aluout` = 0x40, then pulse `flush` together with a new `in_valid` → the next cycle shows `out_valid` = 0 and `memwrite_mem` = 0, the new entry is never output, and `aluout_mem` still reads 0x40.
- Saturation: `SCNT_W` = 4 with a 20-cycle stall → `stall_cnt` stops at 15.

Source files
------------

// File: rtl/exe_mem_stage.sv
// -----------------------------------------------------------------------------
// exe_mem_stage
// EXE->MEM pipeline register for the MIPS pipeline. It captures the ALU result,
// the store data, the destination register and three control bits from the
// execute stage and presents them to the data-memory stage. Transfers use a
// valid/ready handshake. A hazard-unit flush kills everything held or arriving.
// A saturating counter records how many cycles the head entry was stalled.
//
// Optional feature: define EXE_MEM_SKID_EN to add a second (skid) entry, which
// makes in_ready a registered signal instead of a combinational path from
// out_ready. Without the macro the stage holds a single entry.
//
// Parameters:
//   WIDTH   data path width (aluout, writedata)
//   RA_W    register-file address width
//   SCNT_W  stall-counter width
//
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   in_valid / in_ready             upstream handshake
//   regwrite_exe, memtoreg_exe,
//   memwrite_exe                    incoming control bits
//   aluout_exe, writedata_exe,
//   regaddr_exe                     incoming data
//   flush                           drop held and arriving entries
//   out_ready / out_valid           downstream handshake
//   regwrite_mem, memtoreg_mem,
//   memwrite_mem                    control bits gated by out_valid
//   aluout_mem, writedata_mem,
//   regaddr_mem                     head-entry data
//   stall_cnt                       saturating count of stalled cycles
// -----------------------------------------------------------------------------
module exe_mem_stage #(
  parameter int WIDTH  = 32,
  parameter int RA_W   = 5,
  parameter int SCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              regwrite_exe,
  input  logic              memtoreg_exe,
  input  logic              memwrite_exe,
  input  logic [WIDTH-1:0]  aluout_exe,
  input  logic [WIDTH-1:0]  writedata_exe,
  input  logic [RA_W-1:0]   regaddr_exe,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              regwrite_mem,
  output logic              memtoreg_mem,
  output logic              memwrite_mem,
  output logic [WIDTH-1:0]  aluout_mem,
  output logic [WIDTH-1:0]  writedata_mem,
  output logic [RA_W-1:0]   regaddr_mem,
  output logic [SCNT_W-1:0] stall_cnt
);

  // Control bits are kept packed as {regwrite, memtoreg, memwrite}.
  logic              headValid_q, headValid_d;
  logic [2:0]        headCtrl_q, headCtrl_d;
  logic [WIDTH-1:0]  headAlu_q, headAlu_d;
  logic [WIDTH-1:0]  headWd_q, headWd_d;
  logic [RA_W-1:0]   headRa_q, headRa_d;
  logic [SCNT_W-1:0] stallCnt_q, stallCnt_d;

  logic       inXfer;
  logic       outXfer;
  logic [2:0] inCtrl;

  assign inCtrl  = {regwrite_exe, memtoreg_exe, memwrite_exe};
  assign inXfer  = in_valid && in_ready && !flush;
  assign outXfer = headValid_q && out_ready;

`ifdef EXE_MEM_SKID_EN
  logic             skidValid_q, skidValid_d;
  logic [2:0]       skidCtrl_q, skidCtrl_d;
  logic [WIDTH-1:0] skidAlu_q, skidAlu_d;
  logic [WIDTH-1:0] skidWd_q, skidWd_d;
  logic [RA_W-1:0]  skidRa_q, skidRa_d;
  logic             inReady_q, inReady_d;

  // Two-entry FIFO. The skid entry is only filled while the head is stalled,
  // so the head is never empty while the skid holds data; a draining head is
  // refilled from the skid first, which keeps strict FIFO order.
  always_comb begin
    headValid_d = headValid_q;
    headCtrl_d  = headCtrl_q;
    headAlu_d   = headAlu_q;
    headWd_d    = headWd_q;
    headRa_d    = headRa_q;
    skidValid_d = skidValid_q;
    skidCtrl_d  = skidCtrl_q;
    skidAlu_d   = skidAlu_q;
    skidWd_d    = skidWd_q;
    skidRa_d    = skidRa_q;
    if (flush) begin
      headValid_d = 1'b0;
      skidValid_d = 1'b0;
    end else if (!headValid_q || outXfer) begin
      if (skidValid_q) begin
        headValid_d = 1'b1;
        headCtrl_d  = skidCtrl_q;
        headAlu_d   = skidAlu_q;
        headWd_d    = skidWd_q;
        headRa_d    = skidRa_q;
        skidValid_d = 1'b0;
      end else if (inXfer) begin
        headValid_d = 1'b1;
        headCtrl_d  = inCtrl;
        headAlu_d   = aluout_exe;
        headWd_d    = writedata_exe;
        headRa_d    = regaddr_exe;
      end else begin
        headValid_d = 1'b0;
      end
    end else if (inXfer) begin
      skidValid_d = 1'b1;
      skidCtrl_d  = inCtrl;
      skidAlu_d   = aluout_exe;
      skidWd_d    = writedata_exe;
      skidRa_d    = regaddr_exe;
    end
    inReady_d = !skidValid_d;
  end

  // Skid storage and the registered ready flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skidValid_q <= 1'b0;
      skidCtrl_q  <= '0;
      skidAlu_q   <= '0;
      skidWd_q    <= '0;
      skidRa_q    <= '0;
      inReady_q   <= 1'b1;
    end else begin
      skidValid_q <= skidValid_d;
      skidCtrl_q  <= skidCtrl_d;
      skidAlu_q   <= skidAlu_d;
      skidWd_q    <= skidWd_d;
      skidRa_q    <= skidRa_d;
      inReady_q   <= inReady_d;
    end
  end

  assign in_ready = inReady_q;
`else
  // Single entry: accept when empty or when the held entry leaves this cycle.
  assign in_ready = !headValid_q || out_ready;

  // Data registers load only on an accepted input, so they keep their last
  // value across bubbles and flushes.
  always_comb begin
    headCtrl_d = headCtrl_q;
    headAlu_d  = headAlu_q;
    headWd_d   = headWd_q;
    headRa_d   = headRa_q;
    if (flush) begin
      headValid_d = 1'b0;
    end else if (inXfer) begin
      headValid_d = 1'b1;
      headCtrl_d  = inCtrl;
      headAlu_d   = aluout_exe;
      headWd_d    = writedata_exe;
      headRa_d    = regaddr_exe;
    end else if (outXfer) begin
      headValid_d = 1'b0;
    end else begin
      headValid_d = headValid_q;
    end
  end
`endif

  // Counts every cycle the head is held back; flush does not clear it.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (headValid_q && !out_ready && (stallCnt_q != {SCNT_W{1'b1}})) begin
      stallCnt_d = stallCnt_q + SCNT_W'(1);
    end
  end

  // Head entry and stall counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headValid_q <= 1'b0;
      headCtrl_q  <= '0;
      headAlu_q   <= '0;
      headWd_q    <= '0;
      headRa_q    <= '0;
      stallCnt_q  <= '0;
    end else begin
      headValid_q <= headValid_d;
      headCtrl_q  <= headCtrl_d;
      headAlu_q   <= headAlu_d;
      headWd_q    <= headWd_d;
      headRa_q    <= headRa_d;
      stallCnt_q  <= stallCnt_d;
    end
  end

  // Gating the control bits guarantees a bubble never writes anything.
  assign out_valid     = headValid_q;
  assign regwrite_mem  = headCtrl_q[2] & headValid_q;
  assign memtoreg_mem  = headCtrl_q[1] & headValid_q;
  assign memwrite_mem  = headCtrl_q[0] & headValid_q;
  assign aluout_mem    = headAlu_q;
  assign writedata_mem = headWd_q;
  assign regaddr_mem   = headRa_q;
  assign stall_cnt     = stallCnt_q;

endmodule

// File: tb/tb_exe_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_mem_stage
// Self-checking bench for exe_mem_stage. A queue-based reference model tracks
// the entries held by the stage; a second instance with a 4-bit stall counter
// shares all inputs to observe saturation.
// -----------------------------------------------------------------------------
module tb_exe_mem_stage;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  ra;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        regwrite_exe = 1'b0;
  logic        memtoreg_exe = 1'b0;
  logic        memwrite_exe = 1'b0;
  logic [31:0] aluout_exe = '0;
  logic [31:0] writedata_exe = '0;
  logic [4:0]  regaddr_exe = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, regwrite_mem, memtoreg_mem, memwrite_mem;
  logic [31:0] aluout_mem, writedata_mem;
  logic [4:0]  regaddr_mem;
  logic [15:0] stall_cnt;

  logic        satInReady, satOutValid, satRw, satMtr, satMw;
  logic [31:0] satAlu, satWd;
  logic [4:0]  satRa;
  logic [3:0]  satStallCnt;

  entry_t modelQ[$];
  entry_t lastHead;
  int     modelCnt;
  int     modelCntSat;
  int     compCount = 0;
  int     errCount = 0;

  always #5 clk = ~clk;

  exe_mem_stage #(.WIDTH(32), .RA_W(5), .SCNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .regwrite_exe(regwrite_exe), .memtoreg_exe(memtoreg_exe), .memwrite_exe(memwrite_exe),
    .aluout_exe(aluout_exe), .writedata_exe(writedata_exe), .regaddr_exe(regaddr_exe),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem), .memwrite_mem(memwrite_mem),
    .aluout_mem(aluout_mem), .writedata_mem(writedata_mem), .regaddr_mem(regaddr_mem),
    .stall_cnt(stall_cnt)
  );

  exe_mem_stage #(.WIDTH(32), .RA_W(5), .SCNT_W(4)) dutSat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(satInReady),
    .regwrite_exe(regwrite_exe), .memtoreg_exe(memtoreg_exe), .memwrite_exe(memwrite_exe),
    .aluout_exe(aluout_exe), .writedata_exe(writedata_exe), .regaddr_exe(regaddr_exe),
    .flush(flush), .out_ready(out_ready), .out_valid(satOutValid),
    .regwrite_mem(satRw), .memtoreg_mem(satMtr), .memwrite_mem(satMw),
    .aluout_mem(satAlu), .writedata_mem(satWd), .regaddr_mem(satRa),
    .stall_cnt(satStallCnt)
  );

  // Single point of comparison: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stage capacity rules: without skid the stage takes an entry when empty or
  // when the held one leaves; with skid it takes one whenever fewer than two
  // entries are held.
  function automatic logic modelReady(input logic ordy);
`ifdef EXE_MEM_SKID_EN
    return modelQ.size() < 2;
`else
    return (modelQ.size() == 0) || ordy;
`endif
  endfunction

  // Compare every output against the model after a clock edge.
  task automatic checkState();
    entry_t h;
    logic   v;
    v = modelQ.size() > 0;
    h = v ? modelQ[0] : '0;
    checkOutput("out_valid", out_valid, v);
    checkOutput("regwrite_mem", regwrite_mem, h.rw);
    checkOutput("memtoreg_mem", memtoreg_mem, h.mtr);
    checkOutput("memwrite_mem", memwrite_mem, h.mw);
    checkOutput("aluout_mem", aluout_mem, lastHead.alu);
    checkOutput("writedata_mem", writedata_mem, lastHead.wd);
    checkOutput("regaddr_mem", regaddr_mem, lastHead.ra);
    checkOutput("stall_cnt", stall_cnt, modelCnt);
    checkOutput("stall_cnt_sat", satStallCnt, modelCntSat);
  endtask

  // One clock cycle: drive inputs, check in_ready, advance the model, check.
  task automatic applyStimulus(input logic iv, input logic [2:0] c, input logic [31:0] alu,
                               input logic [31:0] wd, input logic [4:0] ra,
                               input logic fl, input logic ordy);
    logic   expReady;
    entry_t e;
    @(negedge clk);
    in_valid = iv;
    {regwrite_exe, memtoreg_exe, memwrite_exe} = c;
    aluout_exe = alu;
    writedata_exe = wd;
    regaddr_exe = ra;
    flush = fl;
    out_ready = ordy;
    #1;
    expReady = modelReady(ordy);
    checkOutput("in_ready", in_ready, expReady);
    e = {c, alu, wd, ra};
    if (modelQ.size() > 0 && !ordy) begin
      if (modelCnt < 65535) modelCnt++;
      if (modelCntSat < 15) modelCntSat++;
    end
    if (fl) begin
      modelQ.delete();
    end else begin
      if (modelQ.size() > 0 && ordy) void'(modelQ.pop_front());
      if (iv && expReady) modelQ.push_back(e);
    end
    if (modelQ.size() > 0) lastHead = modelQ[0];
    @(posedge clk);
    #1;
    checkState();
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, ordy);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    #1;
    modelQ.delete();
    lastHead = '0;
    modelCnt = 0;
    modelCntSat = 0;
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkState();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelCnt = 0;
    modelCntSat = 0;
    lastHead = '0;

    // Reset asserted mid-stall drops the held entry without a clock edge.
    doReset();
    applyStimulus(1'b1, 3'b110, 32'hBEEF, 32'h1111, 5'd7, 1'b0, 1'b1);
    idle(1'b0);
    idle(1'b0);
    checkOutput("pre_rst_stall", stall_cnt, 16'd2);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_out_valid", out_valid, 1'b0);
    checkOutput("async_regwrite", regwrite_mem, 1'b0);
    checkOutput("async_aluout", aluout_mem, 32'h0);
    checkOutput("async_stall_cnt", stall_cnt, 16'd0);
    checkOutput("async_in_ready", in_ready, 1'b1);
    doReset();

    // Streaming: eight back-to-back entries, each visible one cycle later.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'b100, 32'h10 + i, 32'h100 + i, 5'(i + 1), 1'b0, 1'b1);
      checkOutput("stream_alu", aluout_mem, 32'h10 + i);
      checkOutput("stream_valid", out_valid, 1'b1);
    end
    idle(1'b1);

    // Stall: hold 0xABCD while the upstream keeps offering another entry.
    doReset();
    applyStimulus(1'b1, 3'b100, 32'hABCD, 32'h5, 5'd3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'b100, 32'h1234, 32'h6, 5'd4, 1'b0, 1'b0);
      checkOutput("stall_alu", aluout_mem, 32'hABCD);
    end
    checkOutput("stall_cnt_3", stall_cnt, 16'd3);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush together with a new input while a store is held.
    doReset();
    applyStimulus(1'b1, 3'b001, 32'h40, 32'h77, 5'd9, 1'b0, 1'b1);
    checkOutput("store_memwrite", memwrite_mem, 1'b1);
    applyStimulus(1'b1, 3'b001, 32'h99, 32'h88, 5'd10, 1'b1, 1'b1);
    checkOutput("flush_out_valid", out_valid, 1'b0);
    checkOutput("flush_memwrite", memwrite_mem, 1'b0);
    checkOutput("flush_alu_held", aluout_mem, 32'h40);
    idle(1'b1);
    checkOutput("flush_dropped", out_valid, 1'b0);

    // Saturation of the narrow counter over a long stall.
    doReset();
    applyStimulus(1'b1, 3'b010, 32'h55, 32'h66, 5'd2, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) idle(1'b0);
    checkOutput("sat_narrow", satStallCnt, 4'd15);
    checkOutput("sat_wide", stall_cnt, 16'd20);
    idle(1'b1);

    // Randomized traffic against the reference model.
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom), $urandom, $urandom,
                    5'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
    $finish;
  end

endmodule
